fn_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared two-stage logic-function datapath (f1 = a | b, f2 = f1 & c). Accepts operand triples from two independent requesters over valid/ready handshakes and issues at most one per cycle into the pipeline. Each result is returned to the requester that issued it, in order, through a per-requester response buffer. Issue is credit-limited so that no in-flight result can ever overflow a buffer.

---
 rtl/fn_arb_pkg.sv | 19 +
 rtl/fn_arbiter_if.sv | 30 +++
 rtl/fn_arbiter_chk.sv | 16 +
 rtl/fn_pipe.sv | 71 +++++++
 rtl/fn_arbiter.sv | 174 +++++++++++++++++
 tb/tb_fn_arbiter.sv | 252 +++++++++++++++++++++++++
 6 files changed

// File: rtl/fn_arb_pkg.sv
// fn_arb_pkg
//   Shared constants, types and helpers for the two-requester logic-function
//   arbiter (fn_arbiter) and its two-stage datapath (fn_pipe).
//   The result type {f1, f2} depends on WIDTH. It is therefore declared inside
//   fn_arbiter, which owns the WIDTH parameter.
package fn_arb_pkg;

  localparam int unsigned NREQ    = 2;  // number of requesters
  localparam int unsigned MAX_OUT = 2;  // credits per requester (= response FIFO depth)

  typedef logic       id_t;   // requester index travelling with each operation
  typedef logic [1:0] cnt_t;  // credit / FIFO occupancy, 0..2

  // Turns a {valid, id} pair into a per-requester one-hot strobe.
  function automatic logic [NREQ-1:0] id_decode(input logic v, input id_t id);
    return {v & id, v & ~id};
  endfunction

endpackage

// File: rtl/fn_arbiter_if.sv
// fn_arbiter_if
//   Bundles both requesters' operand handshakes and both response handshakes.
//   master : requester side (drives reqK_valid/a/b/c and rspK_ready)
//   slave  : arbiter side   (drives reqK_ready and rspK_valid/f1/f2)
interface fn_arbiter_if #(parameter int unsigned WIDTH = 1);

  logic             req0_valid, req0_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req0_c;
  logic             req1_valid, req1_ready;
  logic [WIDTH-1:0] req1_a, req1_b, req1_c;
  logic             rsp0_valid, rsp0_ready;
  logic [WIDTH-1:0] rsp0_f1, rsp0_f2;
  logic             rsp1_valid, rsp1_ready;
  logic [WIDTH-1:0] rsp1_f1, rsp1_f2;

  modport master (
    output req0_valid, req0_a, req0_b, req0_c, rsp0_ready,
    output req1_valid, req1_a, req1_b, req1_c, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_f1, rsp0_f2,
    input  req1_ready, rsp1_valid, rsp1_f1, rsp1_f2
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_c, rsp0_ready,
    input  req1_valid, req1_a, req1_b, req1_c, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_f1, rsp0_f2,
    output req1_ready, rsp1_valid, rsp1_f1, rsp1_f2
  );

endinterface

// File: rtl/fn_arbiter_chk.sv
// fn_arbiter_chk
//   Property checker for fn_arbiter. It flags any response-FIFO write that
//   lands in a full FIFO without a read in the same cycle.
//   Ports: clk, rst_n, ovf (one flag per requester)
module fn_arbiter_chk
  import fn_arb_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  input logic [NREQ-1:0] ovf
);

  // Credits bound the in-flight plus buffered results at the FIFO depth, so this never fires.
  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n) ovf == {NREQ{1'b0}});

endmodule

// File: rtl/fn_pipe.sv
// fn_pipe
//   Two-stage datapath: stage 1 registers f1 = a | b (plus c), stage 2
//   registers f1 and f2 = f1 & c. A valid bit and the requester id ride along.
//   There is no backpressure: upstream credits guarantee space downstream.
//   Ports: clk, rst_n (async, active-low)
//          in_v, in_id, in_a, in_b, in_c     issue side
//          out_v, out_id, out_f1, out_f2     stage-2 result
module fn_pipe
  import fn_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_v,
  input  id_t              in_id,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  output logic             out_v,
  output id_t              out_id,
  output logic [WIDTH-1:0] out_f1,
  output logic [WIDTH-1:0] out_f2
);

  logic             s1_v_d, s1_v_q, s2_v_d, s2_v_q;
  id_t              s1_id_d, s1_id_q, s2_id_d, s2_id_q;
  logic [WIDTH-1:0] s1_f1_d, s1_f1_q, s1_c_d, s1_c_q;
  logic [WIDTH-1:0] s2_f1_d, s2_f1_q, s2_f2_d, s2_f2_q;

  // Next-state for both pipeline stages.
  always_comb begin
    s1_v_d  = in_v;
    s1_id_d = in_id;
    s1_f1_d = in_a | in_b;
    s1_c_d  = in_c;
    s2_v_d  = s1_v_q;
    s2_id_d = s1_id_q;
    s2_f1_d = s1_f1_q;
    s2_f2_d = s1_f1_q & s1_c_q;
  end

  // Pipeline registers; reset clears valids and data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q  <= 1'b0;
      s1_id_q <= 1'b0;
      s1_f1_q <= {WIDTH{1'b0}};
      s1_c_q  <= {WIDTH{1'b0}};
      s2_v_q  <= 1'b0;
      s2_id_q <= 1'b0;
      s2_f1_q <= {WIDTH{1'b0}};
      s2_f2_q <= {WIDTH{1'b0}};
    end else begin
      s1_v_q  <= s1_v_d;
      s1_id_q <= s1_id_d;
      s1_f1_q <= s1_f1_d;
      s1_c_q  <= s1_c_d;
      s2_v_q  <= s2_v_d;
      s2_id_q <= s2_id_d;
      s2_f1_q <= s2_f1_d;
      s2_f2_q <= s2_f2_d;
    end
  end

  assign out_v  = s2_v_q;
  assign out_id = s2_id_q;
  assign out_f1 = s2_f1_q;
  assign out_f2 = s2_f2_q;

endmodule

// File: rtl/fn_arbiter.sv
// fn_arbiter
//   Two-requester arbiter/sequencer for the f1 = a|b, f2 = f1&c pipeline.
//   Grants at most one operand triple per cycle into fn_pipe, then routes each
//   result into a 2-entry response FIFO for the requester that issued it.
//   Issue is credit-limited, so a FIFO can never overflow.
//   Ports: clk, rst_n (async, active-low), bus (fn_arbiter_if.slave)
//   Build option: FN_ARB_FIXED_PRIO_EN selects fixed priority, where requester 0
//   always wins and there is no pointer register. The default is round-robin.
module fn_arbiter
  import fn_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input logic         clk,
  input logic         rst_n,
  fn_arbiter_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] f1;
    logic [WIDTH-1:0] f2;
  } rsp_t;

  logic [NREQ-1:0]  req_valid_s, rsp_ready_s, elig_s, acc_s, pop_s, wr_s, ovf_s;
  logic             gnt_v_s;
  id_t              gnt_id_s;
  logic [WIDTH-1:0] sel_a_s, sel_b_s, sel_c_s;
  logic             pipe_v_s;
  id_t              pipe_id_s;
  logic [WIDTH-1:0] pipe_f1_s, pipe_f2_s;
  rsp_t             wdata_s;

  cnt_t cnt_d [NREQ], cnt_q [NREQ];    // credits: in flight + buffered
  cnt_t fcnt_d[NREQ], fcnt_q[NREQ];    // FIFO occupancy
  rsp_t head_d[NREQ], head_q[NREQ];    // FIFO entry 0; always the oldest
  rsp_t tail_d[NREQ], tail_q[NREQ];    // FIFO entry 1

  assign req_valid_s = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready_s = {bus.rsp1_ready, bus.rsp0_ready};

`ifndef FN_ARB_FIXED_PRIO_EN
  id_t ptr_d, ptr_q;  // requester that wins the next tie
`endif

  // Eligibility and grant selection.
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      elig_s[k] = req_valid_s[k] && (cnt_q[k] < cnt_t'(MAX_OUT));
    end
    gnt_v_s  = |elig_s;
    gnt_id_s = 1'b0;
`ifdef FN_ARB_FIXED_PRIO_EN
    if (elig_s[0]) begin
      gnt_id_s = 1'b0;
    end else begin
      gnt_id_s = 1'b1;
    end
`else
    case (elig_s)
      2'b11:   gnt_id_s = ptr_q;
      2'b10:   gnt_id_s = 1'b1;
      2'b01:   gnt_id_s = 1'b0;
      default: gnt_id_s = 1'b0;
    endcase
    // The pointer moves past whoever was just granted.
    if (gnt_v_s) begin
      ptr_d = ~gnt_id_s;
    end else begin
      ptr_d = ptr_q;
    end
`endif
  end

  // Operand mux toward the pipeline.
  always_comb begin
    if (gnt_id_s) begin
      sel_a_s = bus.req1_a;
      sel_b_s = bus.req1_b;
      sel_c_s = bus.req1_c;
    end else begin
      sel_a_s = bus.req0_a;
      sel_b_s = bus.req0_b;
      sel_c_s = bus.req0_c;
    end
  end

  assign acc_s          = id_decode(gnt_v_s, gnt_id_s);
  assign bus.req0_ready = acc_s[0];
  assign bus.req1_ready = acc_s[1];

  fn_pipe #(.WIDTH(WIDTH)) u_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_v   (gnt_v_s),
    .in_id  (gnt_id_s),
    .in_a   (sel_a_s),
    .in_b   (sel_b_s),
    .in_c   (sel_c_s),
    .out_v  (pipe_v_s),
    .out_id (pipe_id_s),
    .out_f1 (pipe_f1_s),
    .out_f2 (pipe_f2_s)
  );

  assign wr_s       = id_decode(pipe_v_s, pipe_id_s);
  assign wdata_s.f1 = pipe_f1_s;
  assign wdata_s.f2 = pipe_f2_s;

  // Credit counters and response FIFOs. A read is applied before a write, so a full FIFO may read and write in one cycle.
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      pop_s[k]  = (fcnt_q[k] != 2'd0) && rsp_ready_s[k];
      ovf_s[k]  = wr_s[k] && (fcnt_q[k] == 2'd2) && !pop_s[k];
      cnt_d[k]  = cnt_q[k];
      fcnt_d[k] = fcnt_q[k];
      head_d[k] = head_q[k];
      tail_d[k] = tail_q[k];
      case ({acc_s[k], pop_s[k]})
        2'b10:   cnt_d[k] = cnt_q[k] + 2'd1;
        2'b01:   cnt_d[k] = cnt_q[k] - 2'd1;
        default: cnt_d[k] = cnt_q[k];
      endcase
      // Case key: {occupancy, write, read}.
      case ({fcnt_q[k], wr_s[k], pop_s[k]})
        4'b00_10: begin head_d[k] = wdata_s; fcnt_d[k] = 2'd1; end
        4'b01_10: begin tail_d[k] = wdata_s; fcnt_d[k] = 2'd2; end
        4'b01_01: fcnt_d[k] = 2'd0;
        4'b01_11: head_d[k] = wdata_s;
        4'b10_01: begin head_d[k] = tail_q[k]; fcnt_d[k] = 2'd1; end
        4'b10_11: begin head_d[k] = tail_q[k]; tail_d[k] = wdata_s; end
        default:  fcnt_d[k] = fcnt_q[k];
      endcase
    end
  end

  // State registers; reset discards everything in flight or buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREQ; k++) begin
        cnt_q[k]  <= 2'd0;
        fcnt_q[k] <= 2'd0;
        head_q[k] <= {(2 * WIDTH){1'b0}};
        tail_q[k] <= {(2 * WIDTH){1'b0}};
      end
`ifndef FN_ARB_FIXED_PRIO_EN
      ptr_q <= 1'b0;
`endif
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        cnt_q[k]  <= cnt_d[k];
        fcnt_q[k] <= fcnt_d[k];
        head_q[k] <= head_d[k];
        tail_q[k] <= tail_d[k];
      end
`ifndef FN_ARB_FIXED_PRIO_EN
      ptr_q <= ptr_d;
`endif
    end
  end

  assign bus.rsp0_valid = (fcnt_q[0] != 2'd0);
  assign bus.rsp0_f1    = head_q[0].f1;
  assign bus.rsp0_f2    = head_q[0].f2;
  assign bus.rsp1_valid = (fcnt_q[1] != 2'd0);
  assign bus.rsp1_f1    = head_q[1].f1;
  assign bus.rsp1_f2    = head_q[1].f2;

  fn_arbiter_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .ovf   (ovf_s)
  );

endmodule

// File: tb/tb_fn_arbiter.sv
// tb_fn_arbiter
//   Self-checking bench for fn_arbiter (WIDTH=4). The reference model keeps one
//   queue of outstanding results per requester. Each entry holds f1, f2 and the
//   cycle from which it is visible. Credits are the queue length, and grants
//   follow the round-robin or fixed-priority rule. Defining FN_ARB_FIXED_PRIO_EN
//   selects the fixed-priority model.
module tb_fn_arbiter;

  localparam int unsigned W = 4;

  typedef struct {
    logic [W-1:0] f1;
    logic [W-1:0] f2;
    int           vis;
  } item_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fn_arbiter_if #(.WIDTH(W)) bus ();
  fn_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int    errors = 0;
  int    checks = 0;
  int    cyc    = 0;
  bit    rr     = 1'b0;
  item_t mq [2][$];

  bit           v [2];
  bit           r [2];
  logic [W-1:0] a [2];
  logic [W-1:0] b [2];
  logic [W-1:0] c [2];
  bit           o_rdy [2];
  bit           o_rv  [2];
  logic [W-1:0] o_f1  [2];
  logic [W-1:0] o_f2  [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive();
    bus.req0_valid = v[0]; bus.req0_a = a[0]; bus.req0_b = b[0]; bus.req0_c = c[0];
    bus.req1_valid = v[1]; bus.req1_a = a[1]; bus.req1_b = b[1]; bus.req1_c = c[1];
    bus.rsp0_ready = r[0]; bus.rsp1_ready = r[1];
  endtask

  task automatic sample();
    o_rdy[0] = bus.req0_ready; o_rdy[1] = bus.req1_ready;
    o_rv[0]  = bus.rsp0_valid; o_rv[1]  = bus.rsp1_valid;
    o_f1[0]  = bus.rsp0_f1;    o_f1[1]  = bus.rsp1_f1;
    o_f2[0]  = bus.rsp0_f2;    o_f2[1]  = bus.rsp1_f2;
  endtask

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic step();
    bit    elig [2];
    bit    gv;
    bit    vis;
    int    g;
    item_t it;
    @(negedge clk);
    drive();
    #1;
    sample();
    for (int k = 0; k < 2; k++) elig[k] = v[k] && (mq[k].size() < 2);
    gv = elig[0] | elig[1];
`ifdef FN_ARB_FIXED_PRIO_EN
    g = elig[0] ? 0 : 1;
`else
    g = (elig[0] && elig[1]) ? (rr ? 1 : 0) : (elig[0] ? 0 : 1);
`endif
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("req%0d_ready", k), o_rdy[k], gv && (g == k));
      vis = (mq[k].size() > 0) && (mq[k][0].vis <= cyc);
      check_eq($sformatf("rsp%0d_valid", k), o_rv[k], vis);
      if (vis) begin
        check_eq($sformatf("rsp%0d_f1", k), o_f1[k], mq[k][0].f1);
        check_eq($sformatf("rsp%0d_f2", k), o_f2[k], mq[k][0].f2);
        if (r[k]) void'(mq[k].pop_front());
      end
    end
    if (gv) begin
      it.f1  = a[g] | b[g];
      it.f2  = (a[g] | b[g]) & c[g];
      it.vis = cyc + 3;
      mq[g].push_back(it);
      rr = (g == 0);
    end
    cyc++;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      v[k] = 1'b0; r[k] = 1'b0; a[k] = '0; b[k] = '0; c[k] = '0;
    end
    drive();
    @(negedge clk);
    #1;
    sample();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("%s_ready%0d", tag, k), o_rdy[k], 1'b0);
      check_eq($sformatf("%s_rv%0d", tag, k), o_rv[k], 1'b0);
      check_eq($sformatf("%s_f1_%0d", tag, k), o_f1[k], 4'h0);
      check_eq($sformatf("%s_f2_%0d", tag, k), o_f2[k], 4'h0);
    end
    rst_n = 1'b1;
    mq[0].delete();
    mq[1].delete();
    rr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      v[0] = 1'b0; v[1] = 1'b0; r[0] = 1'b1; r[1] = 1'b1;
      step();
    end
  endtask

  initial begin
    int           acc;
    int           got;
    int           n_ord;
    logic [W-1:0] ta [3];
    logic [W-1:0] tb [3];
    logic [W-1:0] tc [3];
    logic [W-1:0] seen_f1 [$];
    logic [W-1:0] seen_f2 [$];

    do_reset("por");

    // Single issue: the result appears 3 cycles after the accept.
    v[0] = 1'b1; a[0] = 4'b1010; b[0] = 4'b0101; c[0] = 4'b0011; r[0] = 1'b1; r[1] = 1'b1;
    step();
    check_eq("single_ready", o_rdy[0], 1'b1);
    v[0] = 1'b0;
    step();
    step();
    step();
    check_eq("single_rv", o_rv[0], 1'b1);
    check_eq("single_f1", o_f1[0], 4'hF);
    check_eq("single_f2", o_f2[0], 4'h3);
    idle(4);

    // Tie: both requesters valid, both responses always ready.
    do_reset("tie");
    got = 0;
    for (int i = 0; i < 8; i++) begin
      v[0] = 1'b1; v[1] = 1'b1; r[0] = 1'b1; r[1] = 1'b1;
      a[0] = W'(i); b[0] = 4'h1; c[0] = 4'hC;
      a[1] = W'(i + 3); b[1] = 4'h2; c[1] = 4'h6;
      step();
      if (i == 0) check_eq("tie_first", o_rdy[0], 1'b1);
      if (o_rdy[1]) got++;
    end
`ifndef FN_ARB_FIXED_PRIO_EN
    check_eq("tie_rr_req1_grants", got, 4);
`endif
    idle(6);

    // Credit stall: no draining limits requester 0 to two accepts.
    do_reset("stall");
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      v[0] = 1'b1; r[0] = 1'b0; r[1] = 1'b1; a[0] = W'(i + 1); b[0] = 4'h4; c[0] = 4'h5;
      step();
      if (o_rdy[0]) acc++;
    end
    check_eq("stall_acc", acc, 2);
    r[0] = 1'b1;
    step();
    if (o_rdy[0]) acc++;
    r[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (o_rdy[0]) acc++;
    end
    check_eq("stall_acc_after_drain", acc, 3);
    idle(8);

    // Ordering: three distinct triples from requester 1 with a toggling rsp1_ready.
    do_reset("ord");
    ta[0] = 4'h1; tb[0] = 4'h2; tc[0] = 4'h4;
    ta[1] = 4'h8; tb[1] = 4'h1; tc[1] = 4'h9;
    ta[2] = 4'h4; tb[2] = 4'h4; tc[2] = 4'h6;
    n_ord = 0;
    for (int i = 0; i < 3; i++) begin
      got = 0;
      a[1] = ta[i]; b[1] = tb[i]; c[1] = tc[i];
      for (int t = 0; t < 20 && got == 0; t++) begin
        v[1] = 1'b1; r[1] = ~r[1];
        step();
        if (o_rv[1] && r[1]) begin seen_f1.push_back(o_f1[1]); seen_f2.push_back(o_f2[1]); end
        if (o_rdy[1]) got = 1;
      end
      check_eq($sformatf("ord_accept%0d", i), got, 1);
      v[1] = 1'b0;
    end
    for (int t = 0; t < 14; t++) begin
      r[1] = ~r[1];
      step();
      if (o_rv[1] && r[1]) begin seen_f1.push_back(o_f1[1]); seen_f2.push_back(o_f2[1]); end
    end
    n_ord = seen_f1.size();
    check_eq("ord_count", n_ord, 3);
    for (int i = 0; i < 3 && i < n_ord; i++) begin
      check_eq($sformatf("ord_f1_%0d", i), seen_f1[i], ta[i] | tb[i]);
      check_eq($sformatf("ord_f2_%0d", i), seen_f2[i], (ta[i] | tb[i]) & tc[i]);
    end
    idle(4);

    // Random traffic; operands are held stable until accepted.
    do_reset("rnd");
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (!v[k] && ($urandom_range(0, 2) != 0)) begin
          v[k] = 1'b1; a[k] = W'($urandom); b[k] = W'($urandom); c[k] = W'($urandom);
        end
        r[k] = ($urandom_range(0, 3) != 0);
      end
      step();
      for (int k = 0; k < 2; k++) if (o_rdy[k]) v[k] = 1'b0;
    end
    idle(8);

    // Mid-flight reset: in-flight results vanish and the pointer returns to 0.
    v[0] = 1'b1; v[1] = 1'b1; r[0] = 1'b1; r[1] = 1'b1;
    a[0] = 4'h3; b[0] = 4'h0; c[0] = 4'hF; a[1] = 4'h5; b[1] = 4'h0; c[1] = 4'hF;
    step();
    step();
    do_reset("midrst");
    idle(6);
    v[0] = 1'b1; v[1] = 1'b1;
    step();
    check_eq("midrst_tie_req0", o_rdy[0], 1'b1);
    check_eq("midrst_tie_req1", o_rdy[1], 1'b0);
    v[0] = 1'b0; v[1] = 1'b0;
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
